// File: rtl/spi_slave_fifo_if.sv
// Host-side bundle of spi_slave_fifo: TX load handshake,
// RX FIFO pop handshake and status pulses.
interface spi_slave_fifo_if #(
    parameter int RX_W = 8,
    parameter int TX_W = 18
);
    logic [TX_W-1:0] tx_data;
    logic            tx_load;
    logic            tx_ready;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid;
    logic            rx_ready;
    logic            rx_overflow;
    logic            frame_err;
    logic            busy;

    modport master (
        output tx_data, tx_load, rx_ready,
        input  tx_ready, rx_data, rx_valid,
        input  rx_overflow, frame_err, busy
    );

    modport slave (
        input  tx_data, tx_load, rx_ready,
        output tx_ready, rx_data, rx_valid,
        output rx_overflow, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_fifo.sv
// Oversampled SPI target with TX holding register, RX FIFO,
// overflow and partial-frame error pulses; single sys_clk domain.
module spi_slave_fifo #(
    parameter int RX_W     = 8,
    parameter int TX_W     = 18,
    parameter int RX_DEPTH = 4,
    parameter int CPOL     = 0,
    parameter int CPHA     = 0
) (
    input  logic             sys_clk,
    input  logic             rst,
    spi_slave_fifo_if.slave  bus,
    input  logic             spi_clk,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = $clog2(RX_W);
    localparam logic [CW-1:0] LAST = CW'(RX_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nx;

    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;

    // cs history resets low so a frame already in flight at
    // reset release is ignored until cs is seen high.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sclk_q <= {3{CPOL != 0}};
            cs_q   <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_clk};
            cs_q   <= {cs_q[1:0], cs};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    logic sclk_rise, sclk_fall, lead, trail;
    logic sample_e, shift_e, cs_fall, cs_rise, mosi_s;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign lead      = (CPOL == 0) ? sclk_rise : sclk_fall;
    assign trail     = (CPOL == 0) ? sclk_fall : sclk_rise;
    assign sample_e  = (CPHA == 0) ? lead : trail;
    assign shift_e   = (CPHA == 0) ? trail : lead;
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign mosi_s    = mosi_q[1];

    always_ff @(posedge sys_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (cs_fall) state_nx = ACTIVE;
            ACTIVE:  if (cs_rise) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    logic active;
    assign active       = (state == ACTIVE);
    assign bus.busy     = active;
    assign bus.tx_ready = (state == IDLE);

    logic [TX_W-1:0] tx_hold;
    logic [TX_W-1:0] tx_sh;
    logic            tx_on;

    // Zero-fill shifting drives miso low once all TX_W bits
    // are out; tx_on holds miso low until the first bit is due.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tx_hold <= '0;
            tx_sh   <= '0;
            tx_on   <= 1'b0;
        end else begin
            if (!active && bus.tx_load) tx_hold <= bus.tx_data;
            if (!active && cs_fall) begin
                tx_sh <= tx_hold;
                tx_on <= (CPHA == 0);
            end else if (active && cs_rise) begin
                tx_on <= 1'b0;
            end else if (active && shift_e) begin
                if (tx_on) tx_sh <= tx_sh << 1;
                tx_on <= 1'b1;
            end
        end
    end

    assign miso = active & tx_on & tx_sh[TX_W-1];

    logic [RX_W-2:0] rx_sh;
    logic [CW-1:0]   rx_cnt;
    logic [RX_W-1:0] rx_word;
    logic            rx_push;
    logic            ferr_q;

    assign rx_word = {rx_sh, mosi_s};
    assign rx_push = active && !cs_rise && sample_e
                     && (rx_cnt == LAST);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rx_sh  <= '0;
            rx_cnt <= '0;
            ferr_q <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            if (active && cs_rise) begin
                rx_cnt <= '0;
                ferr_q <= (rx_cnt != '0);
            end else if (active && sample_e) begin
                rx_sh  <= rx_word[RX_W-2:0];
                rx_cnt <= (rx_cnt == LAST) ? '0 : rx_cnt + 1'b1;
            end
        end
    end

    assign bus.frame_err = ferr_q;

    logic [RX_W-1:0] mem [RX_DEPTH];
    logic [AW:0]     wp, rp;
    logic            empty, full, pop, push_ok, ovf_q;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW])
                     && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop     = !empty && bus.rx_ready;
    assign push_ok = rx_push && (!full || pop);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= rx_push && full && !pop;
            if (push_ok) wp <= wp + 1'b1;
            if (pop)     rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push_ok) mem[wp[AW-1:0]] <= rx_word;
    end

    assign bus.rx_valid    = !empty;
    assign bus.rx_data     = empty ? '0 : mem[rp[AW-1:0]];
    assign bus.rx_overflow = ovf_q;
endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: mode-0 and mode-3 instances driven
// by a bit-level SPI host, vector table plus random frames.
module tb_spi_slave_fifo;
    localparam int H = 8;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic rst0, rst3;
    logic sclk_p [2];
    logic cs_p   [2];
    logic mosi_p [2];
    logic miso_p [2];

    spi_slave_fifo_if #(.RX_W(8), .TX_W(18)) if0 ();
    spi_slave_fifo_if #(.RX_W(8), .TX_W(18)) if3 ();

    spi_slave_fifo #(
        .RX_W(8), .TX_W(18), .RX_DEPTH(4), .CPOL(0), .CPHA(0)
    ) dut0 (
        .sys_clk (sys_clk),
        .rst     (rst0),
        .bus     (if0.slave),
        .spi_clk (sclk_p[0]),
        .cs      (cs_p[0]),
        .mosi    (mosi_p[0]),
        .miso    (miso_p[0])
    );

    spi_slave_fifo #(
        .RX_W(8), .TX_W(18), .RX_DEPTH(4), .CPOL(1), .CPHA(1)
    ) dut3 (
        .sys_clk (sys_clk),
        .rst     (rst3),
        .bus     (if3.slave),
        .spi_clk (sclk_p[1]),
        .cs      (cs_p[1]),
        .mosi    (mosi_p[1]),
        .miso    (miso_p[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    int fe_cnt [2] = '{0, 0};
    int ov_cnt [2] = '{0, 0};
    logic [7:0] got0 [$];
    logic [7:0] got3 [$];

    always @(posedge sys_clk) begin
        if (if0.rx_valid && if0.rx_ready) got0.push_back(if0.rx_data);
        if (if3.rx_valid && if3.rx_ready) got3.push_back(if3.rx_data);
        if (if0.frame_err === 1'b1) fe_cnt[0]++;
        if (if3.frame_err === 1'b1) fe_cnt[1]++;
        if (if0.rx_overflow === 1'b1) ov_cnt[0]++;
        if (if3.rx_overflow === 1'b1) ov_cnt[1]++;
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_h();
        repeat (H) @(negedge sys_clk);
    endtask

    task automatic set_rdy(bit m, logic v);
        if (m) if3.rx_ready = v;
        else   if0.rx_ready = v;
    endtask

    function automatic logic get_valid(bit m);
        return m ? if3.rx_valid : if0.rx_valid;
    endfunction

    task automatic load_tx(bit m, logic [17:0] v);
        @(negedge sys_clk);
        if (m) begin if3.tx_data = v; if3.tx_load = 1'b1; end
        else   begin if0.tx_data = v; if0.tx_load = 1'b1; end
        @(negedge sys_clk);
        if3.tx_load = 1'b0;
        if0.tx_load = 1'b0;
    endtask

    // m=0: CPOL0/CPHA0 host, m=1: CPOL1/CPHA1 host.
    task automatic xfer(bit m, int n, logic [63:0] bits, logic rdy,
                        output logic [63:0] cap);
        cap = '0;
        @(negedge sys_clk);
        set_rdy(m, rdy);
        cs_p[m] = 1'b0;
        wait_h();
        for (int i = 0; i < n; i++) begin
            if (!m) begin
                mosi_p[m] = bits[n-1-i];
                wait_h();
                cap = {cap[62:0], miso_p[m]};
                sclk_p[m] = 1'b1;
                wait_h();
                sclk_p[m] = 1'b0;
            end else begin
                sclk_p[m] = 1'b0;
                mosi_p[m] = bits[n-1-i];
                wait_h();
                cap = {cap[62:0], miso_p[m]};
                sclk_p[m] = 1'b1;
                wait_h();
            end
        end
        wait_h();
        cs_p[m] = 1'b1;
        repeat (3) wait_h();
        set_rdy(m, 1'b0);
    endtask

    task automatic drain(bit m);
        @(negedge sys_clk);
        set_rdy(m, 1'b1);
        for (int k = 0; k < 40 && get_valid(m); k++)
            @(negedge sys_clk);
        chk("drain_empty", get_valid(m), 0);
        set_rdy(m, 1'b0);
    endtask

    task automatic cmp_words(bit m, string nm, int nw,
                             logic [31:0] w);
        logic [7:0] g [$];
        if (m) begin g = got3; got3.delete(); end
        else   begin g = got0; got0.delete(); end
        chk({nm, "_nw"}, g.size(), nw);
        for (int k = 0; k < nw && k < g.size(); k++)
            chk($sformatf("%s_w%0d", nm, k), g[k], w[8*k +: 8]);
    endtask

    typedef struct {
        int          n;
        logic [63:0] mosi;
        bit          load;
        logic [17:0] tx;
        logic [63:0] miso;
        int          fe;
        int          ov;
        int          nw;
        logic [31:0] w;
    } vec_t;

    initial begin
        vec_t        tab [5];
        logic [63:0] cap, bits, em;
        logic [17:0] hold, txv;
        logic [7:0]  expq [$];
        int          fe0, ov0, n, occ, eov, efe;
        logic        rdy;

        tab[0] = '{8, 64'hA5, 1, 18'h2ABCD, 64'hAA,
                   0, 0, 1, 32'h000000A5};
        tab[1] = '{24, 64'h112233, 0, 18'h0, 64'hAAF340,
                   0, 0, 3, 32'h00332211};
        tab[2] = '{40, 64'hDEADBEEF01, 1, 18'h00001,
                   64'h400000, 0, 1, 4, 32'hEFBEADDE};
        tab[3] = '{5, 64'h16, 0, 18'h0, 64'h0,
                   1, 0, 0, 32'h0};
        tab[4] = '{8, 64'h3C, 1, 18'h3FFFF, 64'hFF,
                   0, 0, 1, 32'h0000003C};

        rst0 = 1'b1; rst3 = 1'b1;
        sclk_p[0] = 1'b0; sclk_p[1] = 1'b1;
        cs_p[0] = 1'b1; cs_p[1] = 1'b1;
        mosi_p[0] = 1'b0; mosi_p[1] = 1'b0;
        if0.tx_data = '0; if0.tx_load = 1'b0; if0.rx_ready = 1'b0;
        if3.tx_data = '0; if3.tx_load = 1'b0; if3.rx_ready = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_out0", {if0.tx_ready, if0.busy, miso_p[0],
            if0.rx_valid, if0.rx_data, if0.rx_overflow,
            if0.frame_err}, {7'b1000000, 7'b0});
        chk("rst_out3", {if3.tx_ready, if3.busy, miso_p[1],
            if3.rx_valid, if3.rx_data, if3.rx_overflow,
            if3.frame_err}, {7'b1000000, 7'b0});
        rst0 = 1'b0; rst3 = 1'b0;
        repeat (6) @(negedge sys_clk);

        for (int i = 0; i < 5; i++) begin
            if (tab[i].load) load_tx(0, tab[i].tx);
            fe0 = fe_cnt[0];
            ov0 = ov_cnt[0];
            xfer(0, tab[i].n, tab[i].mosi, 1'b0, cap);
            chk($sformatf("v%0d_miso", i), cap, tab[i].miso);
            chk($sformatf("v%0d_ferr", i), fe_cnt[0] - fe0, tab[i].fe);
            chk($sformatf("v%0d_ovf", i), ov_cnt[0] - ov0, tab[i].ov);
            drain(0);
            cmp_words(0, $sformatf("v%0d", i), tab[i].nw, tab[i].w);
        end

        // reset in the middle of a frame, with a word queued
        xfer(0, 8, 64'h77, 1'b0, cap);
        chk("pre_rst_valid", if0.rx_valid, 1);
        @(negedge sys_clk);
        cs_p[0] = 1'b0;
        wait_h();
        for (int i = 0; i < 4; i++) begin
            mosi_p[0] = 1'b1; wait_h();
            sclk_p[0] = 1'b1; wait_h();
            sclk_p[0] = 1'b0;
        end
        chk("pre_rst_busy", if0.busy, 1);
        rst0 = 1'b1;
        repeat (2) @(negedge sys_clk);
        chk("midrst_out", {if0.tx_ready, if0.busy, miso_p[0],
            if0.rx_valid, if0.rx_data, if0.rx_overflow,
            if0.frame_err}, {7'b1000000, 7'b0});
        rst0 = 1'b0;
        fe0 = fe_cnt[0];
        for (int i = 0; i < 8; i++) begin
            mosi_p[0] = 1'b1; wait_h();
            sclk_p[0] = 1'b1; wait_h();
            sclk_p[0] = 1'b0;
        end
        chk("post_rst_busy", if0.busy, 0);
        chk("post_rst_valid", if0.rx_valid, 0);
        wait_h();
        cs_p[0] = 1'b1;
        repeat (3) wait_h();
        chk("post_rst_ferr", fe_cnt[0] - fe0, 0);
        got0.delete();
        hold = '0;

        occ = 0;
        for (int it = 0; it < 30; it++) begin
            n    = $urandom_range(40, 1);
            bits = {$urandom(), $urandom()};
            if ($urandom_range(1, 0) == 1) begin
                txv = 18'($urandom());
                load_tx(0, txv);
                hold = txv;
            end
            rdy = ($urandom_range(2, 0) == 0);
            em = '0;
            for (int i = 0; i < n; i++)
                em = {em[62:0], (i < 18) ? hold[17-i] : 1'b0};
            eov = 0;
            for (int k = 0; k < n / 8; k++) begin
                if (rdy || occ < 4) begin
                    expq.push_back(bits[n-1-8*k -: 8]);
                    if (!rdy) occ++;
                end else begin
                    eov++;
                end
            end
            if (rdy) occ = 0;
            efe = (n % 8 != 0) ? 1 : 0;
            fe0 = fe_cnt[0];
            ov0 = ov_cnt[0];
            xfer(0, n, bits, rdy, cap);
            chk("rnd_miso", cap, em);
            chk("rnd_ferr", fe_cnt[0] - fe0, efe);
            chk("rnd_ovf", ov_cnt[0] - ov0, eov);
            if ($urandom_range(1, 0) == 1 || it == 29) begin
                drain(0);
                occ = 0;
            end
            while (got0.size() > 0 && expq.size() > 0)
                chk("rnd_word", got0.pop_front(), expq.pop_front());
        end
        chk("rnd_left", got0.size() + expq.size(), 0);

        // mode 3, with a tx_load attempted mid-frame
        load_tx(1, 18'h155);
        fe0 = fe_cnt[1];
        fork
            xfer(1, 24, 64'h5A0FF0, 1'b0, cap);
            begin
                repeat (60) @(negedge sys_clk);
                chk("m3_busy", {if3.busy, if3.tx_ready}, 2'b10);
                load_tx(1, 18'h3FFFF);
            end
        join
        chk("m3_miso", cap, 64'h5540);
        drain(1);
        cmp_words(1, "m3a", 3, 32'h00F00F5A);
        xfer(1, 24, 64'h0, 1'b0, cap);
        chk("m3_miso_keep", cap, 64'h5540);
        chk("m3_ferr", fe_cnt[1] - fe0, 0);
        drain(1);
        cmp_words(1, "m3b", 3, 32'h0);
        fe0 = fe_cnt[1];
        xfer(1, 11, 64'h5A5, 1'b0, cap);
        chk("m3_partial_ferr", fe_cnt[1] - fe0, 1);
        drain(1);
        cmp_words(1, "m3c", 1, 32'h000000B4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
